updown_counter_param: RTL and testbench



---
 rtl/updown_counter_param.sv | 72 +++++++
 tb/tb_updown_counter_param.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with load, wrap/saturate, tc and roll pulse
// Priority per edge is rst > load > enable; roll is registered and flags the edge that wrapped.
module updown_counter_param #(
  parameter int               WIDTH    = 5,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic             up,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             roll
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             roll_q, roll_d;
  logic [WIDTH-1:0] load_val;
  logic             at_max, at_min;

  // A full-range counter can hold any load value, so the clamp only exists for short moduli.
  if (MAX_VAL == {WIDTH{1'b1}}) begin : g_no_clamp
    assign load_val = data;
  end else begin : g_clamp
    assign load_val = (data > MAX_VAL) ? MAX_VAL : data;
  end

  assign at_max = (count_q == MAX_VAL);
  assign at_min = (count_q == '0);

  always_comb begin
    count_d = count_q;
    roll_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (enable) begin
      if (up) begin
        if (!at_max) begin
          count_d = count_q + WIDTH'(1);
        end else if (!SATURATE) begin
          count_d = '0;
          roll_d  = 1'b1;
        end
      end else begin
        if (!at_min) begin
          count_d = count_q - WIDTH'(1);
        end else if (!SATURATE) begin
          count_d = MAX_VAL;
          roll_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      roll_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      roll_q  <= roll_d;
    end
  end

  assign count = count_q;
  assign roll  = roll_q;
  assign tc    = up ? at_max : at_min;

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - directed self-checking bench for updown_counter_param
// Four instances share one stimulus set: default, MAX_VAL=9 wrap, MAX_VAL=9 saturate, WIDTH=2 MAX_VAL=1.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       enable;
  logic       up;
  logic [4:0] data;

  logic [4:0] cnt_def, cnt_m9, cnt_sat;
  logic [1:0] cnt_m1;
  logic       tc_def, tc_m9, tc_sat, tc_m1;
  logic       roll_def, roll_m9, roll_sat, roll_m1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  updown_counter_param u_def (
    .clk(clk), .rst(rst), .load(load), .enable(enable), .up(up), .data(data),
    .count(cnt_def), .tc(tc_def), .roll(roll_def)
  );

  updown_counter_param #(.WIDTH(5), .MAX_VAL(5'd9), .SATURATE(1'b0)) u_m9 (
    .clk(clk), .rst(rst), .load(load), .enable(enable), .up(up), .data(data),
    .count(cnt_m9), .tc(tc_m9), .roll(roll_m9)
  );

  updown_counter_param #(.WIDTH(5), .MAX_VAL(5'd9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .load(load), .enable(enable), .up(up), .data(data),
    .count(cnt_sat), .tc(tc_sat), .roll(roll_sat)
  );

  updown_counter_param #(.WIDTH(2), .MAX_VAL(2'd1), .SATURATE(1'b0)) u_m1 (
    .clk(clk), .rst(rst), .load(load), .enable(enable), .up(up), .data(data[1:0]),
    .count(cnt_m1), .tc(tc_m1), .roll(roll_m1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; enable = 1'b0; up = 1'b1; data = '0;
    #12;
    total++;
    if (cnt_def !== 5'd0 || cnt_m9 !== 5'd0 || cnt_sat !== 5'd0 || cnt_m1 !== 2'd0) begin
      bad++;
      $display("FAIL reset_count def=%0h m9=%0h sat=%0h m1=%0h exp=0", cnt_def, cnt_m9, cnt_sat, cnt_m1);
    end
    total++;
    if ({roll_def, roll_m9, roll_sat, roll_m1} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_roll got=%b exp=0000", {roll_def, roll_m9, roll_sat, roll_m1});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    logic [4:0] exp_c;
    enable = 1'b1; up = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_c = 5'(i);
      total++;
      if (cnt_def !== exp_c) begin
        bad++;
        $display("FAIL count_up[%0d] got=%0h exp=%0h", i, cnt_def, exp_c);
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (cnt_def !== 5'd4 || roll_def !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold[%0d] got=%0h roll=%b exp=4 roll=0", i, cnt_def, roll_def);
      end
    end
  endtask

  task automatic test_wrap_default();
    logic [4:0] exp_c [3];
    logic       exp_tc [3];
    logic       exp_r [3];
    exp_c  = '{5'h1E, 5'h1F, 5'h00};
    exp_tc = '{1'b0, 1'b1, 1'b0};
    exp_r  = '{1'b0, 1'b0, 1'b1};
    load = 1'b1; enable = 1'b1; up = 1'b1; data = 5'h1D;
    tick();
    total++;
    if (cnt_def !== 5'h1D || roll_def !== 1'b0) begin
      bad++;
      $display("FAIL load_wins got=%0h roll=%b exp=1d roll=0", cnt_def, roll_def);
    end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (cnt_def !== exp_c[i] || tc_def !== exp_tc[i] || roll_def !== exp_r[i]) begin
        bad++;
        $display("FAIL wrap_up[%0d] got=%0h tc=%b roll=%b exp=%0h tc=%b roll=%b",
                 i, cnt_def, tc_def, roll_def, exp_c[i], exp_tc[i], exp_r[i]);
      end
    end
    enable = 1'b0;
    tick();
    total++;
    if (roll_def !== 1'b0) begin
      bad++;
      $display("FAIL roll_one_cycle got=%b exp=0", roll_def);
    end
  endtask

  task automatic test_clamp_m9();
    load = 1'b1; enable = 1'b0; up = 1'b1; data = 5'h1F;
    tick();
    total++;
    if (cnt_m9 !== 5'd9 || tc_m9 !== 1'b1) begin
      bad++;
      $display("FAIL clamp_m9 got=%0h tc=%b exp=9 tc=1", cnt_m9, tc_m9);
    end
    total++;
    if (cnt_m1 !== 2'd1 || cnt_def !== 5'h1F) begin
      bad++;
      $display("FAIL clamp_other m1=%0h def=%0h exp m1=1 def=1f", cnt_m1, cnt_def);
    end
    load = 1'b0; enable = 1'b1;
    tick();
    total++;
    if (cnt_m9 !== 5'd0 || roll_m9 !== 1'b1) begin
      bad++;
      $display("FAIL m9_wrap_up got=%0h roll=%b exp=0 roll=1", cnt_m9, roll_m9);
    end
    up = 1'b0;
    tick();
    total++;
    if (cnt_m9 !== 5'd9 || roll_m9 !== 1'b1) begin
      bad++;
      $display("FAIL m9_wrap_down got=%0h roll=%b exp=9 roll=1", cnt_m9, roll_m9);
    end
    enable = 1'b0;
    tick();
    total++;
    if (roll_m9 !== 1'b0 || cnt_m9 !== 5'd9) begin
      bad++;
      $display("FAIL m9_idle got=%0h roll=%b exp=9 roll=0", cnt_m9, roll_m9);
    end
  endtask

  task automatic test_saturate();
    logic [4:0] exp_c;
    load = 1'b1; enable = 1'b0; up = 1'b1; data = 5'd8;
    tick();
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (cnt_sat !== 5'd9 || roll_sat !== 1'b0 || tc_sat !== 1'b1) begin
        bad++;
        $display("FAIL sat_up[%0d] got=%0h roll=%b tc=%b exp=9 roll=0 tc=1", i, cnt_sat, roll_sat, tc_sat);
      end
    end
    load = 1'b1; enable = 1'b0; data = 5'd1;
    tick();
    load = 1'b0; enable = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_c = 5'd0;
      total++;
      if (cnt_sat !== exp_c || roll_sat !== 1'b0 || tc_sat !== 1'b1) begin
        bad++;
        $display("FAIL sat_down[%0d] got=%0h roll=%b tc=%b exp=0 roll=0 tc=1", i, cnt_sat, roll_sat, tc_sat);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b0; enable = 1'b0; up = 1'b1;
    do_reset();
    enable = 1'b1;
    repeat (7) tick();
    total++;
    if (cnt_def !== 5'd7) begin
      bad++;
      $display("FAIL pre_reset_count got=%0h exp=7", cnt_def);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (cnt_def !== 5'd0 || roll_def !== 1'b0 || cnt_m1 !== 2'd0) begin
      bad++;
      $display("FAIL async_reset got=%0h roll=%b m1=%0h exp=0 roll=0 m1=0", cnt_def, roll_def, cnt_m1);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++;
    if (cnt_def !== 5'd1) begin
      bad++;
      $display("FAIL first_after_reset got=%0h exp=1", cnt_def);
    end
  endtask

  task automatic test_direction_change();
    logic [4:0] exp_c [4];
    logic       exp_r [4];
    exp_c = '{5'd2, 5'd1, 5'd0, 5'h1F};
    exp_r = '{1'b0, 1'b0, 1'b0, 1'b1};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = (i == 0);
      tick();
      total++;
      if (cnt_def !== exp_c[i] || roll_def !== exp_r[i]) begin
        bad++;
        $display("FAIL dir_change[%0d] got=%0h roll=%b exp=%0h roll=%b", i, cnt_def, roll_def, exp_c[i], exp_r[i]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_tc_direction();
    load = 1'b0; enable = 1'b0; up = 1'b0;
    do_reset();
    #1;
    total++;
    if (tc_def !== 1'b1) begin
      bad++;
      $display("FAIL tc_down_zero got=%b exp=1", tc_def);
    end
    up = 1'b1;
    #1;
    total++;
    if (tc_def !== 1'b0 || cnt_def !== 5'd0) begin
      bad++;
      $display("FAIL tc_up_zero got=%b count=%0h exp tc=0 count=0", tc_def, cnt_def);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_c [4];
    logic       exp_r [4];
    exp_c = '{2'd1, 2'd0, 2'd1, 2'd0};
    exp_r = '{1'b0, 1'b1, 1'b0, 1'b1};
    load = 1'b0; up = 1'b1; enable = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (cnt_m1 !== exp_c[i] || roll_m1 !== exp_r[i]) begin
        bad++;
        $display("FAIL m1_run[%0d] got=%0h roll=%b exp=%0h roll=%b", i, cnt_m1, roll_m1, exp_c[i], exp_r[i]);
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_default();
    test_clamp_m9();
    test_saturate();
    test_async_reset();
    test_direction_change();
    test_tc_direction();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
